serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to add a, b, cin; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured on accepted start.
REQ-006 b  input  WIDTH  operand B, captured on accepted start.
REQ-007 cin  input  1  carry-in, captured on accepted start.
REQ-008 busy  output  1  high while bits are being processed (RUN).
REQ-009 done  output  1  one-cycle pulse: sum/cout valid.
REQ-010 sum  output  WIDTH  result bits, registered.
REQ-011 cout  output  1  final carry-out, registered.

Function
REQ-012 Block SHALL compute a + b + cin bit-serially, LSB first, using exactly one 1-bit full-adder instance for all bits.
REQ-013 FSM SHALL have states IDLE, RUN, DONE.
REQ-014 IDLE with start=1 at an edge: load A/B shift registers from a/b, carry register from cin, bit counter to 0, go to RUN.
REQ-015 IDLE with start=0: stay in IDLE; registers hold.
REQ-016 Each RUN edge: feed A[0], B[0], carry to the full adder; shift its sum bit into result MSB (result shifts right); carry <= adder cout; A, B shift right; counter increments.
REQ-017 RUN edge with counter == WIDTH-1: process the final bit, go to DONE.
REQ-018 DONE: done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
REQ-019 Latency: done SHALL be high in the cycle after the (WIDTH+1)th rising edge counted from the start-accepting edge; busy high for exactly WIDTH cycles.
REQ-020 sum SHALL equal (a+b+cin) mod 2^WIDTH and cout SHALL equal bit WIDTH of the sum; both driven from registers, stable from DONE until the next accepted start.
REQ-021 start during RUN or DONE SHALL be ignored; no queuing. Changes to a/b/cin after acceptance SHALL NOT affect the result.
REQ-022 Back-to-back: start held high SHALL be accepted on the first IDLE edge after DONE (one idle cycle between operations).
REQ-023 busy and done SHALL never be high simultaneously.
REQ-024 Counter SHALL be $clog2(WIDTH) bits wide; it SHALL NOT wrap inside RUN.

Reset
REQ-025 rst=1 at an edge: state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0, shift registers 0.
REQ-026 rst SHALL take priority over start and over any in-progress operation; an operation aborted by rst SHALL produce no done pulse.
REQ-027 start asserted together with rst SHALL be ignored.

Structure
REQ-028 State encodings (IDLE=0, RUN=1, DONE=2) and default WIDTH SHALL live in a shared constants file used by RTL and bench.
REQ-029 One sub-module: the existing full_adder (ports a, b, cin, sum, cout), instantiated once; all sequencing is in serial_adder_ctrl.
REQ-030 No combinational path from start, a, b or cin to any output.

Verification (WIDTH=4)
REQ-031 a=5, b=3, cin=0, start 1 cycle -> busy 4 cycles, done pulse, sum=8, cout=0.
REQ-032 a=F, b=1, cin=0 -> sum=0, cout=1; a=F, b=F, cin=1 -> sum=F, cout=1.
REQ-033 Start accepted, a/b changed to 0 and start re-pulsed during RUN -> original result delivered, single done pulse, second start ignored.
REQ-034 rst asserted in 2nd RUN cycle -> next cycle IDLE, busy=0, sum=0, cout=0; no done pulse afterwards.
REQ-035 start held high continuously with a=1, b=1, cin=0 -> done every 6 cycles, sum=2 each time.
REQ-036 Exhaustive sweep of all a, b, cin combinations -> every result matches a+b+cin.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings and default operand width.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle of the bit-serial adder, plus the FSM state for observation.
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
    #(parameter int WIDTH = DEFAULT_WIDTH) ();

    // Handshake: start is a request sampled only while idle (busy=0, done=0); there is
    // no ready, a start seen in RUN or DONE is dropped. done is a one-cycle pulse after
    // which sum/cout hold until the next accepted start completes.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    state_t           state;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, state
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, state
    );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder shared by every bit position of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: a + b + cin computed LSB first through a single full adder,
// sequenced by an IDLE/RUN/DONE controller.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
    #(parameter int WIDTH = DEFAULT_WIDTH) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, sum_q;
    logic             carry, cout_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum, fa_cout;
    logic             last_bit;

    assign last_bit = (cnt == LAST_BIT);

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
                    carry  <= fa_cout;
                    if (last_bit) begin
                        sum_q  <= {fa_sum, res_sr[WIDTH-1:1]};
                        cout_q <= fa_cout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.state = state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed checks of the 4-bit serial adder: latency, results, abort, back-to-back, sweep.
module tb_serial_adder_ctrl;
    import serial_adder_ctrl_pkg::*;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;
    logic [W:0] exp_q[$];

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.busy && bus.done) begin
            n_checks = n_checks + 1;
            n_fail   = n_fail + 1;
            $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both high", bus.busy, bus.done);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one start pulse from IDLE and waits for done; returns {cout,sum} and busy count.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output logic [W:0] res, output int busy_cnt, output logic got);
        bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) got = 1'b1;
        end
        res = {bus.cout, bus.sum};
        @(posedge clk); #1;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic [W:0] exp);
        logic [W:0] res;
        int         bc;
        logic       got;
        run_op(a, b, c, res, bc, got);
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd4);
        check({tag, "_sum"}, 32'(res[W-1:0]), 32'(exp[W-1:0]));
        check({tag, "_cout"}, 32'(res[W]), 32'(exp[W]));
    endtask

    initial begin
        logic [W:0] res;
        logic [W:0] exp_v;
        int         bc;
        int         n_done;
        int         done_cyc[$];
        logic       got;

        n_checks = 0; n_fail = 0; cyc = 0;
        rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", 32'(bus.state), 32'(IDLE));
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_sum", 32'(bus.sum), 32'd0);
        check("reset_cout", 32'(bus.cout), 32'd0);
        @(posedge clk); #1;

        // hand-computed vectors
        directed("add_5_3", 4'h5, 4'h3, 1'b0, 5'h08);
        directed("add_f_1", 4'hF, 4'h1, 1'b0, 5'h10);
        directed("add_f_f_c", 4'hF, 4'hF, 1'b1, 5'h1F);
        directed("add_0_0_c", 4'h0, 4'h0, 1'b1, 5'h01);

        // result held after done while inputs move
        bus.a = 4'h2; bus.b = 4'h7; bus.cin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold_sum", 32'(bus.sum), 32'h1);
        check("hold_cout", 32'(bus.cout), 32'h0);
        @(posedge clk); #1;

        // 9+4+1 = 14; operands zeroed and start re-pulsed mid-run
        bus.a = 4'h9; bus.b = 4'h4; bus.cin = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("ignore_start_done_count", 32'(n_done), 32'd1);
        check("ignore_start_sum", 32'(bus.sum), 32'hE);
        check("ignore_start_cout", 32'(bus.cout), 32'h0);
        @(posedge clk); #1;

        // reset in the second RUN cycle
        bus.a = 4'h7; bus.b = 4'h6; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("abort_running", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_state", 32'(bus.state), 32'(IDLE));
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        @(posedge clk); #1;

        // start together with reset is dropped
        bus.a = 4'h3; bus.b = 4'h3; rst = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check("rst_start_state", 32'(bus.state), 32'(IDLE));
        check("rst_start_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;

        // start held high: done every 6 cycles, 1+1=2
        bus.a = 4'h1; bus.b = 4'h1; bus.cin = 1'b0; bus.start = 1'b1;
        done_cyc.delete();
        for (int i = 0; i < 30 && done_cyc.size() < 3; i++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cyc.push_back(cyc);
                check("b2b_sum", 32'(bus.sum), 32'h2);
                check("b2b_cout", 32'(bus.cout), 32'h0);
            end
        end
        bus.start = 1'b0;
        check("b2b_done_count", 32'(done_cyc.size()), 32'd3);
        if (done_cyc.size() == 3) begin
            check("b2b_period_1", 32'(done_cyc[1] - done_cyc[0]), 32'd6);
            check("b2b_period_2", 32'(done_cyc[2] - done_cyc[1]), 32'd6);
        end
        repeat (3) @(posedge clk);
        #1;

        // exhaustive sweep through the expected queue
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    exp_q.push_back(5'(a + b + c));
                    run_op(4'(a), 4'(b), 1'(c), res, bc, got);
                    exp_v = exp_q.pop_front();
                    if (!got) check("sweep_done", 32'(got), 32'd1);
                    else      check($sformatf("sweep_%0d_%0d_%0d", a, b, c), 32'(res), 32'(exp_v));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
